instruction_decode_stage: RTL
=============================

Name: instruction_decode_stage

Overview:
- IF/ID pipeline stage directly downstream of instruction fetch. Captures the fetched instruction and its PC, then decodes RV32I-subset fields.
- Outputs a registered control bundle, register indices and sign-extended immediate to the execute stage.
- Owns load-use hazard detection. Requests a fetch stall and inserts a bubble toward execute.
- Supports flush (taken branch) and external stall.

Parameters:
- XLEN, 32, datapath / PC / immediate width
- REG_ADDR_W, 5, register index width

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  fetch presents a valid instruction this cycle
- instruction  input  32  fetched instruction word
- pc  input  XLEN  PC of instruction
- stall  input  1  downstream stall: hold all output registers
- flush  input  1  discard current decode, emit bubble
- ex_mem_read  input  1  instruction now in execute is a load
- ex_rd  input  5  destination of instruction now in execute
- hazard_stall  output  1  combinational: fetch must hold PC and instruction
- out_valid  output  1  registered: outputs describe a real instruction
- pc_out  output  XLEN  registered PC
- rs1, rs2, rd  output  5 each  registered register indices
- imm  output  XLEN  registered sign-extended immediate
- reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, branch_ne  output  1 each  registered controls
- alu_op  output  4  registered ALU operation code
- illegal  output  1  registered: one-cycle pulse for an unsupported opcode or funct

Behaviour:
- Reset (reset_n low, asynchronous):
  - All registered outputs are 0, including out_valid and illegal.
  - Release is synchronous to clk.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N.
- Priority at each edge is flush > stall > hazard > normal load.
  - flush: out_valid, all controls and illegal go to 0. pc_out, indices and imm may hold.
  - stall (no flush): every output register holds, including illegal.
  - hazard_stall (no flush/stall): load a bubble, i.e. controls 0 and out_valid 0. Fetch holds, so the same instruction is re-presented next cycle.
  - normal: load decoded fields; out_valid = in_valid. When in_valid is 0, all controls are 0.
- hazard_stall = in_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == rs1_dec & uses_rs1) | (ex_rd == rs2_dec & uses_rs2)).
  - uses_rs1 applies to R, I-ALU, load, store and branch.
  - uses_rs2 applies to R, store and branch.
  - hazard_stall is masked to 0 when flush is 1.
- Decode by opcode:
  - 0110011 R-type: reg_write=1, alu_src=0. funct3/funct7 select ADD, SUB, AND, OR, XOR, SLL, SRL.
  - 0010011 I-ALU: reg_write=1, alu_src=1. ADDI, ANDI, ORI, XORI.
  - 0000011 funct3=010 LW: reg_write, mem_read, mem_to_reg, alu_src set; alu_op=ADD.
  - 0100011 funct3=010 SW: mem_write, alu_src set; alu_op=ADD; rd output forced to 0.
  - 1100011 BEQ/BNE: branch=1; branch_ne = funct3[0]; alu_op=SUB; rd forced to 0.
  - Anything else, or unsupported funct: illegal=1 with out_valid=0 and controls 0. illegal is set only when in_valid.
- Immediates:
  - I: sign-extend instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - R-type: 0.
- Writes to x0: reg_write is forced to 0 when rd == 0.
- Reset mid-stall or mid-hazard returns to the bubble state; no residual hazard is remembered.

Decomposition:
- Shared package decode_pkg:
  - opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH
  - funct3/funct7 constants
  - ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_SLL=5, ALU_SRL=6
- One sub-module, imm_gen: combinational instruction -> imm by format.
- Decoder and hazard logic stay in this module.

Test Plan:
- add x3,x1,x2 (0x002081B3), in_valid=1 -> next cycle: out_valid=1, rs1=1, rs2=2, rd=3, reg_write=1, alu_op=1 is wrong, so check alu_op=0 (ADD), imm=0.
- lw x5,8(x2) (0x00812283), then ex_mem_read=1, ex_rd=5 with add x6,x5,x1 at input -> hazard_stall=1; next outputs are a bubble (out_valid=0). With ex_mem_read=0 the following cycle, the add decodes.
- sw x5,-4(x2) (0xFE512E23) -> imm=0xFFFFFFFC, mem_write=1, alu_src=1, reg_write=0, rd=0.
- beq x1,x2,-8 (0xFE208CE3) -> imm=0xFFFFFFF8, branch=1, branch_ne=0, alu_op=1; same instruction with flush=1 -> out_valid=0, branch=0.
- stall=1 for 3 cycles while input changes -> outputs frozen. Assert reset_n=0 mid-stall -> all outputs 0 immediately, without waiting for a clock edge.
- 0xFFFFFFFF with in_valid=1 -> illegal=1 for one cycle, out_valid=0; addi x0,x0,1 -> reg_write=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode constants, control bundle and immediate-format helper for the ID stage.
package decode_pkg;

  // Major opcodes of the supported RV32I subset
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  typedef enum logic [1:0] {ImmNone, ImmI, ImmS, ImmB} imm_fmt_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       branch_ne;
    logic [3:0] alu_op;
  } ctrl_t;

  // Immediate layout implied by the opcode; R-type and unknown opcodes carry no immediate
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_IMM, OP_LOAD: fmt = ImmI;
      OP_STORE:        fmt = ImmS;
      OP_BRANCH:       fmt = ImmB;
      default:         fmt = ImmNone;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: sign-extends the I/S/B immediate selected by opcode.
module imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm
);

  // rs1/funct3 bits never contribute to any supported immediate
  logic unused_bits;
  assign unused_bits = ^instruction[19:12];

  // Assemble the immediate for the format of this opcode
  always_comb begin
    imm = '0;
    case (imm_fmt(instruction[6:0]))
      ImmI: imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
      ImmS: imm = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
      ImmB: imm = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// IF/ID stage: decodes the fetched RV32I-subset instruction into a registered control bundle,
// detects load-use hazards against the instruction in execute, and handles flush/stall.
module instruction_decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [31:0]           instruction,
  input  logic [XLEN-1:0]       pc,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  hazard_stall,
  output logic                  out_valid,
  output logic [XLEN-1:0]       pc_out,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       imm,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  alu_src,
  output logic                  branch,
  output logic                  branch_ne,
  output logic [3:0]            alu_op,
  output logic                  illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [REG_ADDR_W-1:0] rs1_dec, rs2_dec, rd_field, rd_dec;
  logic [XLEN-1:0] imm_dec;
  ctrl_t ctrl_dec;
  logic  illegal_dec, uses_rs1, uses_rs2;

  logic                  valid_d, valid_q;
  logic                  illegal_d, illegal_q;
  ctrl_t                 ctrl_d, ctrl_q;
  logic [XLEN-1:0]       pc_d, pc_q;
  logic [REG_ADDR_W-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [XLEN-1:0]       imm_d, imm_q;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7   = instruction[31:25];
  assign rs1_dec  = instruction[15 +: REG_ADDR_W];
  assign rs2_dec  = instruction[20 +: REG_ADDR_W];
  assign rd_field = instruction[7 +: REG_ADDR_W];

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instruction(instruction),
    .imm        (imm_dec)
  );

  // Opcode/funct decode into controls; unsupported encodings flag illegal with no controls
  always_comb begin
    ctrl_dec    = '0;
    illegal_dec = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    rd_dec      = rd_field;
    case (opcode)
      OP_R: begin
        uses_rs1           = 1'b1;
        uses_rs2           = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD_SUB}: ctrl_dec.alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD_SUB}: ctrl_dec.alu_op = ALU_SUB;
          {F7_BASE, F3_AND}:     ctrl_dec.alu_op = ALU_AND;
          {F7_BASE, F3_OR}:      ctrl_dec.alu_op = ALU_OR;
          {F7_BASE, F3_XOR}:     ctrl_dec.alu_op = ALU_XOR;
          {F7_BASE, F3_SLL}:     ctrl_dec.alu_op = ALU_SLL;
          {F7_BASE, F3_SRL}:     ctrl_dec.alu_op = ALU_SRL;
          default:               illegal_dec     = 1'b1;
        endcase
      end
      OP_IMM: begin
        uses_rs1           = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        case (funct3)
          F3_ADD_SUB: ctrl_dec.alu_op = ALU_ADD;
          F3_AND:     ctrl_dec.alu_op = ALU_AND;
          F3_OR:      ctrl_dec.alu_op = ALU_OR;
          F3_XOR:     ctrl_dec.alu_op = ALU_XOR;
          default:    illegal_dec     = 1'b1;
        endcase
      end
      OP_LOAD: begin
        uses_rs1 = 1'b1;
        if (funct3 == F3_LW) begin
          ctrl_dec.reg_write  = 1'b1;
          ctrl_dec.mem_read   = 1'b1;
          ctrl_dec.mem_to_reg = 1'b1;
          ctrl_dec.alu_src    = 1'b1;
          ctrl_dec.alu_op     = ALU_ADD;
        end else begin
          illegal_dec = 1'b1;
        end
      end
      OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        rd_dec   = '0;
        if (funct3 == F3_SW) begin
          ctrl_dec.mem_write = 1'b1;
          ctrl_dec.alu_src   = 1'b1;
          ctrl_dec.alu_op    = ALU_ADD;
        end else begin
          illegal_dec = 1'b1;
        end
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        rd_dec   = '0;
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          ctrl_dec.branch    = 1'b1;
          ctrl_dec.branch_ne = funct3[0];
          ctrl_dec.alu_op    = ALU_SUB;
        end else begin
          illegal_dec = 1'b1;
        end
      end
      default: illegal_dec = 1'b1;
    endcase
    if (illegal_dec) begin
      ctrl_dec = '0;
    end
    // x0 is hardwired, so a write to it is dropped here rather than in the register file
    if (rd_dec == '0) begin
      ctrl_dec.reg_write = 1'b0;
    end
  end

  // Load-use hazard: a load in execute targets a source register this instruction reads
  always_comb begin
    hazard_stall = in_valid & ex_mem_read & ~flush & (ex_rd != '0) &
                   (((ex_rd == rs1_dec) & uses_rs1) | ((ex_rd == rs2_dec) & uses_rs2));
  end

  // Next-state selection with priority flush > stall > hazard > normal load
  always_comb begin
    valid_d   = valid_q;
    illegal_d = illegal_q;
    ctrl_d    = ctrl_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    if (flush) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      ctrl_d    = '0;
    end else if (stall) begin
      // hold everything
    end else if (hazard_stall) begin
      // fetch re-presents this instruction next cycle, so only a bubble goes out now
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      ctrl_d    = '0;
    end else begin
      valid_d   = in_valid & ~illegal_dec;
      illegal_d = in_valid & illegal_dec;
      ctrl_d    = in_valid ? ctrl_dec : '0;
      pc_d      = pc;
      rs1_d     = rs1_dec;
      rs2_d     = rs2_dec;
      rd_d      = rd_dec;
      imm_d     = imm_dec;
    end
  end

  // ID/EX output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
    end
  end

  assign out_valid  = valid_q;
  assign illegal    = illegal_q;
  assign pc_out     = pc_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign rd         = rd_q;
  assign imm        = imm_q;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src    = ctrl_q.alu_src;
  assign branch     = ctrl_q.branch;
  assign branch_ne  = ctrl_q.branch_ne;
  assign alu_op     = ctrl_q.alu_op;

endmodule
